// File: rtl/prod_acc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// prod_acc : saturating accumulator that sums len product words into one result
// Revision : 1.0
// ----------------------------------------------------------------------------
module prod_acc #(
    parameter int ACC_W = 20,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [LEN_W-1:0] len,
    input  logic [16:0]      P,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] S,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [ACC_W-1:0] C_ACC_MAX = {ACC_W{1'b1}};

    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [LEN_W:0]   cnt_q, cnt_d;
    logic [LEN_W:0]   len_q, len_d;
    logic             ovf_q, ovf_d;

    logic [LEN_W:0]   len_eff;
    logic [LEN_W:0]   cnt_inc;
    logic [ACC_W:0]   sum_wide;

    // A zero length word stands for the maximum term count.
    assign len_eff  = (len == '0) ? (LEN_W+1)'(1 << LEN_W) : {1'b0, len};
    assign cnt_inc  = cnt_q + 1'b1;
    assign sum_wide = {1'b0, acc_q} + (ACC_W+1)'(P);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        if (clr) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        len_d   = len_eff;
                        acc_d   = ACC_W'(P);
                        cnt_d   = (LEN_W+1)'(1);
                        ovf_d   = 1'b0;
                        state_d = (len_eff == (LEN_W+1)'(1)) ? ST_HOLD : ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (in_valid) begin
                        // The extra carry bit flags any overflow before clamping.
                        if (sum_wide[ACC_W]) begin
                            acc_d = C_ACC_MAX;
                            ovf_d = 1'b1;
                        end else begin
                            acc_d = sum_wide[ACC_W-1:0];
                        end
                        cnt_d = cnt_inc;
                        if (cnt_inc == len_q) begin
                            state_d = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        S         = '0;
        ovf       = 1'b0;
        case (state_q)
            ST_IDLE, ST_ACC: begin
                in_ready = !clr;
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                S         = acc_q;
                ovf       = ovf_q;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_prod_acc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_prod_acc : scoreboard bench for the saturating product accumulator
// Revision    : 1.0
// ----------------------------------------------------------------------------
module tb_prod_acc;

    localparam int ACC_W = 20;
    localparam int LEN_W = 4;
    localparam longint C_MAX = (64'd1 << ACC_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clr;
    logic [LEN_W-1:0] len;
    logic [16:0]      P;
    logic             in_valid;
    logic             in_ready;
    logic [ACC_W-1:0] S;
    logic             ovf;
    logic             out_valid;
    logic             out_ready;

    int errors = 0;
    int checks = 0;
    int results_seen = 0;

    logic [ACC_W:0] exp_q[$];

    int terms[16];
    int gaps[16];

    prod_acc #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .len       (len),
        .P         (P),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .S         (S),
        .ovf       (ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Scoreboard: every result handed over downstream is checked in order.
    always @(negedge clk) begin
        if (rst_n && !clr && out_valid && out_ready) begin
            logic [ACC_W:0] e;
            checks++;
            results_seen++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result got S=%0d ovf=%0d with empty scoreboard", S, ovf);
            end else begin
                e = exp_q.pop_front();
                if ({ovf, S} !== e) begin
                    errors++;
                    $display("FAIL result got S=%0d ovf=%0d expected S=%0d ovf=%0d",
                             S, ovf, e[ACC_W-1:0], e[ACC_W]);
                end
            end
        end
    end

    task automatic wait_result(input int seen_before, input string name);
        int n = 0;
        while (results_seen == seen_before && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (results_seen == seen_before) begin
            errors++;
            $display("FAIL %s_timeout got no result expected one within 40 cycles", name);
        end
    endtask

    // One term presented for exactly one edge; out_valid must rise only after the last.
    task automatic send_term(input int p, input bit last, input string name);
        in_valid = 1'b1;
        P = 17'(p);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_in_ready got %b expected 1", name, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== last) begin
            errors++;
            $display("FAIL %s_latency got out_valid=%b expected %b", name, out_valid, last);
        end
    endtask

    // Drives n terms from terms[] with gaps[] idle cycles after each, out_ready high.
    task automatic do_sum(input int n_len, input int n, input string name);
        longint acc = 0;
        bit     o   = 1'b0;
        int     seen;
        for (int i = 0; i < n; i++) begin
            acc += terms[i];
            if (acc > C_MAX) begin
                acc = C_MAX;
                o   = 1'b1;
            end
        end
        exp_q.push_back({o, ACC_W'(acc)});
        seen = results_seen;
        out_ready = 1'b1;
        len = LEN_W'(n_len);
        for (int i = 0; i < n; i++) begin
            send_term(terms[i], i == n - 1, name);
            if (i == 0) len = LEN_W'($urandom_range(1, 15));
            if (i != n - 1) repeat (gaps[i]) @(posedge clk);
            #1;
        end
        wait_result(seen, name);
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_pulse got out_valid=%b expected 0 after consume", name, out_valid);
        end
    endtask

    task automatic clear_gaps();
        for (int i = 0; i < 16; i++) gaps[i] = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; len = '0; P = '0; in_valid = 1'b0; out_ready = 1'b0;
        #3;
        checks++;
        if (out_valid !== 1'b0 || S !== '0 || ovf !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset got out_valid=%b S=%0d ovf=%b in_ready=%b expected 0 0 0 1",
                     out_valid, S, ovf, in_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        clear_gaps();
        terms[0] = 100; terms[1] = 200; terms[2] = 300;
        do_sum(3, 3, "basic");
    endtask

    task automatic test_len0();
        clear_gaps();
        for (int i = 0; i < 16; i++) terms[i] = 65025;
        do_sum(0, 16, "len0");
    endtask

    task automatic test_len1_backpressure();
        int seen;
        out_ready = 1'b0;
        len = 4'd1;
        exp_q.push_back({1'b0, ACC_W'(7)});
        seen = results_seen;
        send_term(7, 1'b1, "len1");
        in_valid = 1'b1;
        P = 17'd99;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || S !== ACC_W'(7) || in_ready !== 1'b0 || ovf !== 1'b0) begin
                errors++;
                $display("FAIL len1_hold cycle %0d got out_valid=%b S=%0d in_ready=%b ovf=%b expected 1 7 0 0",
                         i, out_valid, S, in_ready, ovf);
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_result(seen, "len1");
        @(posedge clk);
        #1;
    endtask

    task automatic test_saturation();
        clear_gaps();
        for (int i = 0; i < 10; i++) terms[i] = 17'h1FFFF;
        do_sum(10, 10, "sat");
        terms[0] = 1; terms[1] = 2;
        do_sum(2, 2, "after_sat");
    endtask

    task automatic test_stalls();
        terms[0] = 5; terms[1] = 6; terms[2] = 7; terms[3] = 8;
        gaps[0] = 1; gaps[1] = 3; gaps[2] = 0;
        do_sum(4, 4, "stall");
        clear_gaps();
    endtask

    task automatic test_clr();
        out_ready = 1'b1;
        len = 4'd3;
        send_term(50, 1'b0, "clr_first");
        in_valid = 1'b1;
        P = 17'd60;
        clr = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL clr_in_ready got %b expected 0", in_ready);
        end
        @(posedge clk);
        #1;
        clr = 1'b0;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL clr_idle got out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
        end
        terms[0] = 9; terms[1] = 9;
        do_sum(2, 2, "after_clr");
    endtask

    task automatic test_reset_in_hold();
        out_ready = 1'b0;
        len = 4'd1;
        send_term(5, 1'b1, "rst_hold");
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || S !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset got out_valid=%b S=%0d in_ready=%b expected 0 0 1",
                     out_valid, S, in_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        terms[0] = 3; terms[1] = 4;
        do_sum(2, 2, "after_rst");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len0();
        test_len1_backpressure();
        test_saturation();
        test_stalls();
        test_clr();
        test_reset_in_hold();
        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
